// File: rtl/seq_counter_if.sv
// Control/status bundle for the Simon sequence/round counter.
// The game controller takes the master side, the counter the slave side.
interface seq_counter_if #(
    parameter int WIDTH = 5
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             at_limit;
    logic             at_min;
    logic             wrapped;
    logic             underflow;

    modport master (
        output clear, load, load_val, inc, dec, limit,
        input  count, at_limit, at_min, wrapped, underflow
    );

    modport slave (
        input  clear, load, load_val, inc, dec, limit,
        output count, at_limit, at_min, wrapped, underflow
    );
endinterface

// File: rtl/seq_counter.sv
// Parametrised round/position counter for the Simon datapath.
// State changes on the falling edge of clk. Priority is clear > load > inc/dec.
// WRAP selects wrap-around or saturation at both limits. Every attempt to step
// past a limit produces a one-cycle registered pulse: wrapped or underflow.
module seq_counter #(
    parameter int WIDTH     = 5,
    parameter int MIN_VAL   = 1,
    parameter int RESET_VAL = 1,
    parameter int WRAP      = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             wrapped_r;
    logic             underflow_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             wrapped_nxt_s;
    logic             underflow_nxt_s;

    // Force a loaded value into the legal window [MIN_V, lim].
    function automatic logic [WIDTH-1:0] clamp_val(
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH-1:0] r;
        if (v < MIN_V) begin
            r = MIN_V;
        end else if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state and event-pulse decode. The pulses default to zero on every edge.
    always_comb begin
        count_nxt_s     = count_r;
        wrapped_nxt_s   = 1'b0;
        underflow_nxt_s = 1'b0;
        if (bus.clear) begin
            count_nxt_s = RESET_V;
        end else if (bus.load) begin
            count_nxt_s = clamp_val(bus.load_val, bus.limit);
        end else if (bus.inc && !bus.dec) begin
            // The >= test also covers a limit lowered below count. It keeps
            // count+1 from being taken at the all-ones value.
            if (count_r < bus.limit) begin
                count_nxt_s = count_r + ONE_V;
            end else begin
                wrapped_nxt_s = 1'b1;
                if (WRAP != 0) begin
                    count_nxt_s = MIN_V;
                end else begin
                    count_nxt_s = count_r;
                end
            end
        end else if (bus.dec && !bus.inc) begin
            // A decrement above limit is not clamped. It simply steps down.
            if (count_r > MIN_V) begin
                count_nxt_s = count_r - ONE_V;
            end else begin
                underflow_nxt_s = 1'b1;
                if (WRAP != 0) begin
                    count_nxt_s = bus.limit;
                end else begin
                    count_nxt_s = count_r;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and pulse registers. They update on the falling edge and reset asynchronously.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r     <= RESET_V;
            wrapped_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            wrapped_r   <= wrapped_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    assign bus.count     = count_r;
    assign bus.wrapped   = wrapped_r;
    assign bus.underflow = underflow_r;
    assign bus.at_limit  = (count_r >= bus.limit);
    assign bus.at_min    = (count_r == MIN_V);

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter. It drives a wrapping instance and a
// saturating instance with identical controls and checks both against
// hand-computed expected values.
module tb_seq_counter;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    seq_counter_if #(.WIDTH(5)) bus_w ();
    seq_counter_if #(.WIDTH(5)) bus_s ();

    seq_counter #(.WIDTH(5), .MIN_VAL(1), .RESET_VAL(1), .WRAP(1)) u_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_w.slave)
    );

    seq_counter #(.WIDTH(5), .MIN_VAL(1), .RESET_VAL(1), .WRAP(0)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_s.slave)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [4:0] lv,
                         input logic i, input logic d, input logic [4:0] lim);
        bus_w.clear = c; bus_w.load = l; bus_w.load_val = lv;
        bus_w.inc = i;   bus_w.dec = d;  bus_w.limit = lim;
        bus_s.clear = c; bus_s.load = l; bus_s.load_val = lv;
        bus_s.inc = i;   bus_s.dec = d;  bus_s.limit = lim;
    endtask

    // One active (falling) edge, then settle well before the next edge.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    initial begin
        int exp_w  [5];
        int exp_wp [5];
        int exp_wl [5];
        int exp_s  [5];
        int exp_sp [5];
        int exp_sl [5];
        n_assert = 0;
        n_fail   = 0;

        // Reset held across three edges with inc requested.
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4);
        step(); step(); step();
        chk("rst_count_w", 32'(bus_w.count), 32'd1);
        chk("rst_wrapped_w", 32'(bus_w.wrapped), 32'd0);
        chk("rst_underflow_w", 32'(bus_w.underflow), 32'd0);
        chk("rst_count_s", 32'(bus_s.count), 32'd1);
        chk("rst_at_min_w", 32'(bus_w.at_min), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4);
        reset_n = 1'b1;

        // Wrap vs saturate, limit 4, five increments from 1.
        exp_w  = '{2, 3, 4, 1, 2};
        exp_wp = '{0, 0, 0, 1, 0};
        exp_wl = '{0, 0, 1, 0, 0};
        exp_s  = '{2, 3, 4, 4, 4};
        exp_sp = '{0, 0, 0, 1, 1};
        exp_sl = '{0, 0, 1, 1, 1};
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("inc_count_w[%0d]", k), 32'(bus_w.count), 32'(exp_w[k]));
            chk($sformatf("inc_wrapped_w[%0d]", k), 32'(bus_w.wrapped), 32'(exp_wp[k]));
            chk($sformatf("inc_at_limit_w[%0d]", k), 32'(bus_w.at_limit), 32'(exp_wl[k]));
            chk($sformatf("inc_count_s[%0d]", k), 32'(bus_s.count), 32'(exp_s[k]));
            chk($sformatf("inc_wrapped_s[%0d]", k), 32'(bus_s.wrapped), 32'(exp_sp[k]));
            chk($sformatf("inc_at_limit_s[%0d]", k), 32'(bus_s.at_limit), 32'(exp_sl[k]));
        end

        // One more increment: wrap instance 2 -> 3, saturating one pulses again.
        step();
        chk("pre_rst_count_w", 32'(bus_w.count), 32'd3);
        chk("pre_rst_wrapped_s", 32'(bus_s.wrapped), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4);
        // Mid-cycle reset: takes effect with no clock edge and kills the pulse.
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count_w", 32'(bus_w.count), 32'd1);
        chk("async_rst_count_s", 32'(bus_s.count), 32'd1);
        chk("async_rst_wrapped_s", 32'(bus_s.wrapped), 32'd0);
        #1;
        reset_n = 1'b1;

        // Down and underflow, limit 6.
        drive(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 5'd6);
        step();
        chk("load2_count_w", 32'(bus_w.count), 32'd2);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
        step();
        chk("dec1_count_w", 32'(bus_w.count), 32'd1);
        chk("dec1_underflow_w", 32'(bus_w.underflow), 32'd0);
        chk("dec1_at_min_w", 32'(bus_w.at_min), 32'd1);
        step();
        chk("dec2_count_w", 32'(bus_w.count), 32'd6);
        chk("dec2_underflow_w", 32'(bus_w.underflow), 32'd1);
        chk("dec2_count_s", 32'(bus_s.count), 32'd1);
        chk("dec2_underflow_s", 32'(bus_s.underflow), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6);
        step();
        chk("idle_underflow_w", 32'(bus_w.underflow), 32'd0);
        chk("idle_count_w", 32'(bus_w.count), 32'd6);

        // Priority and load clamping, limit 10.
        drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd10);
        step();
        chk("prio_clear_count_w", 32'(bus_w.count), 32'd1);
        chk("prio_clear_wrapped_w", 32'(bus_w.wrapped), 32'd0);
        drive(1'b0, 1'b1, 5'd20, 1'b1, 1'b0, 5'd10);
        step();
        chk("load_hi_clamp_w", 32'(bus_w.count), 32'd10);
        chk("load_hi_wrapped_w", 32'(bus_w.wrapped), 32'd0);
        drive(1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
        step();
        chk("load_lo_clamp_w", 32'(bus_w.count), 32'd1);
        chk("load_lo_underflow_w", 32'(bus_w.underflow), 32'd0);
        drive(1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd10);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd10);
        step();
        chk("incdec_hold_w", 32'(bus_w.count), 32'd5);
        chk("incdec_wrapped_w", 32'(bus_w.wrapped), 32'd0);
        chk("incdec_underflow_w", 32'(bus_w.underflow), 32'd0);

        // Limit lowered below count, then inc.
        drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd10);
        step();
        chk("lim_pre_at_limit_w", 32'(bus_w.at_limit), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5);
        #1;
        chk("lim_drop_at_limit_w", 32'(bus_w.at_limit), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5);
        step();
        chk("lim_inc_count_w", 32'(bus_w.count), 32'd1);
        chk("lim_inc_wrapped_w", 32'(bus_w.wrapped), 32'd1);
        chk("lim_inc_count_s", 32'(bus_s.count), 32'd7);
        chk("lim_inc_wrapped_s", 32'(bus_s.wrapped), 32'd1);

        // Limit lowered below count, then dec: plain decrement, no clamp.
        drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd10);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
        step();
        chk("lim_dec_count_w", 32'(bus_w.count), 32'd6);
        chk("lim_dec_underflow_w", 32'(bus_w.underflow), 32'd0);
        chk("lim_dec_at_limit_w", 32'(bus_w.at_limit), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
